pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised next-PC generator that owns the PC register for the single-cycle CPU core.
//  Adds the following beyond the plain next-PC combiner:
//   - reset vector;
//   - stall and redirect (exception/flush) inputs;
//   - register-indirect jumps;
//   - a small return-address stack (RAS) for JAL/return pairs.
//  Sits between the control unit/register file and the instruction memory address port.
// PARAMETERS
//  AW        32            PC width in bits; legal range 30..64
//  RESET_PC  32'h0000_3000 PC loaded on reset; truncated/zero-extended to AW
//  RAS_DEPTH 4             return-address stack entries; power of two, 2..16
// PORTS
//  clk           in   1      core clock, rising edge
//  rstn          in   1      asynchronous active-low reset
//  stall_i       in   1      hold PC and RAS this cycle
//  redirect_i    in   1      exception/flush: force PC to redirect_pc_i
//  redirect_pc_i in   AW     redirect target
//  npc_op_i      in   3      next-PC operation; codes in shared package
//  br_taken_i    in   1      branch condition result; used only for BRANCH
//  imm_i         in   26     instr[25:0]: branch offset in [15:0], jump index in [25:0]
//  rs_i          in   AW     register operand for JR/RET
//  pc_o          out  AW     current PC (registered)
//  pcplus4_o     out  AW     pc_o + 4, combinational; link value for JAL
//  npc_o         out  AW     next PC, combinational
//  ras_empty_o   out  1      RAS holds no valid entries (registered)
//  ret_miss_o    out  1      one-cycle pulse: last RET prediction disagreed with rs_i
// BEHAVIOUR
//  Reset (async, rstn=0):
//   - pc_o=RESET_PC; RAS count=0, top pointer=0; ras_empty_o=1; ret_miss_o=0.
//   - A reset mid-stall or mid-redirect discards everything.
//  Arithmetic:
//   - All sums are modulo 2^AW.
//   - BRANCH target = pcplus4 + sext(imm_i[15:0],AW-2)<<2.
//   - JUMP/JAL target = {pcplus4[AW-1:28], imm_i, 2'b00}.
//  npc_o selection by npc_op_i:
//   - PLUS4:      pcplus4.
//   - BRANCH:     branch target if br_taken_i, else pcplus4.
//   - JUMP:       jump target.
//   - JAL:        jump target; push pcplus4 onto RAS.
//   - JR:         rs_i.
//   - RET:        RAS top if not empty, else rs_i; pop if not empty.
//   - Undefined codes: pcplus4, no RAS effect.
//  PC update each posedge, in priority order:
//   - redirect_i: pc<=redirect_pc_i. Takes precedence over stall; RAS unchanged.
//   - stall_i: pc and RAS hold; no push/pop; ret_miss_o<=0.
//   - otherwise: pc<=npc_o; RAS push/pop committed.
//   - Latency: op presented in cycle N takes effect on pc_o in cycle N+1.
//  RAS:
//   - Circular buffer.
//   - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
//   - Pop when empty is a no-op.
//  ret_miss_o:
//   - Set for one cycle after a committed RET with a non-empty RAS and RAS top != rs_i.
//   - The PC still follows the RAS value. The core checks the miss and redirects.
//  Bits [1:0] of every target are passed through unchanged; no alignment trap here.
// STRUCTURE
//  Shared package (ctrl_encode_def.v):
//   - NPC_PLUS4=3'b000, NPC_BRANCH=3'b001, NPC_JUMP=3'b010,
//     NPC_JAL=3'b011, NPC_JR=3'b100, NPC_RET=3'b101.
//   - Default RESET_PC constant.
//  Sub-module npc_ras:
//   - Parameters AW, RAS_DEPTH.
//   - Ports: push, pop, din, top, empty, full.
//   - Pointer arithmetic modulo RAS_DEPTH.
//  Top level holds the PC register, target muxes and ret_miss flop.
// TESTING
//  1. Reset, then PLUS4 x3
//     -> pc_o 0x3000, 0x3004, 0x3008, 0x300C.
//  2. pc=0x3010, BRANCH, taken, imm=16'hFFFE
//     -> next pc 0x300C; same with br_taken_i=0 -> 0x3014.
//  3. pc=0x3020, JAL, imm=26'h0000400
//     -> pc 0x1000, RAS top 0x3024.
//     Then RET with rs_i=0x3024 -> pc 0x3024, ras_empty_o=1, ret_miss_o=0.
//  4. Five nested JALs with RAS_DEPTH=4, then five RETs
//     -> four correct returns; fifth uses rs_i; no pop underflow.
//  5. stall_i and redirect_i together, redirect_pc_i=0x4180
//     -> pc 0x4180, RAS unchanged.
//     Stall alone with JAL -> pc and RAS unchanged.
//  6. RET with RAS top 0x3024 and rs_i=0x5000
//     -> pc 0x3024, ret_miss_o high exactly one cycle.
//     Assert rstn low mid-sequence -> immediate return to reset values.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared next-PC operation encodings and the default reset vector.
package pc_sequencer_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JAL    = 3'b011;
  localparam logic [2:0] NPC_JR     = 3'b100;
  localparam logic [2:0] NPC_RET    = 3'b101;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Return-address stack: circular buffer whose pointer always addresses the
// current top entry. Pushing when full wraps onto the oldest entry, so the
// newest RAS_DEPTH return addresses are always kept.
module npc_ras #(
  parameter int AW        = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [AW-1:0] stack_mem [RAS_DEPTH];
  logic [PW-1:0] top_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;

  // Power-of-two depth lets the pointer wrap naturally at its width.
  assign ptr_inc = PW'(top_ptr_reg + 1'b1);
  assign ptr_dec = PW'(top_ptr_reg - 1'b1);

  assign top   = stack_mem[top_ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(RAS_DEPTH));

  // Entry storage: a push lands one slot above the top; push+pop replaces the top in place.
  always_ff @(posedge clk) begin
    if (push && !pop) begin
      stack_mem[ptr_inc] <= din;
    end else if (push && pop) begin
      stack_mem[top_ptr_reg] <= din;
    end
  end

  // Top pointer and occupancy: count saturates on push, pop of an empty stack is ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      top_ptr_reg <= '0;
      count_reg   <= '0;
    end else if (push && !pop) begin
      top_ptr_reg <= ptr_inc;
      if (!full) begin
        count_reg <= CW'(count_reg + 1'b1);
      end
    end else if (pop && !push && !empty) begin
      top_ptr_reg <= ptr_dec;
      count_reg   <= CW'(count_reg - 1'b1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC generator owning the core PC register: reset vector, stall,
// redirect, branches, jumps, register-indirect jumps and a return-address
// stack that predicts RET targets.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int          AW        = 32,
  parameter logic [63:0] RESET_PC  = 64'(DEFAULT_RESET_PC),
  parameter int          RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  input  logic [2:0]    npc_op_i,
  input  logic          br_taken_i,
  input  logic [25:0]   imm_i,
  input  logic [AW-1:0] rs_i,
  output logic [AW-1:0] pc_o,
  output logic [AW-1:0] pcplus4_o,
  output logic [AW-1:0] npc_o,
  output logic          ras_empty_o,
  output logic          ret_miss_o
);

  logic [AW-1:0] pc_reg;
  logic          ret_miss_reg;
  logic [AW-1:0] br_offset;
  logic [AW-1:0] br_target;
  logic [AW-1:0] jump_target;
  logic [AW-1:0] ras_top;
  logic          ras_empty;
  logic          ras_full_unused;
  logic          commit;
  logic          ras_push;
  logic          ras_pop;

  assign pcplus4_o = pc_reg + AW'(4);

  // Word offset sign-extended, then scaled to bytes.
  assign br_offset   = {{(AW-18){imm_i[15]}}, imm_i[15:0], 2'b00};
  assign br_target   = pcplus4_o + br_offset;
  assign jump_target = {pcplus4_o[AW-1:28], imm_i, 2'b00};

  // Only an unstalled, unredirected cycle may change the stack.
  assign commit   = !redirect_i && !stall_i;
  assign ras_push = commit && (npc_op_i == NPC_JAL);
  assign ras_pop  = commit && (npc_op_i == NPC_RET) && !ras_empty;

  // Next-PC select; unknown codes fall through to sequential execution.
  always_comb begin
    npc_o = pcplus4_o;
    case (npc_op_i)
      NPC_PLUS4:  npc_o = pcplus4_o;
      NPC_BRANCH: npc_o = br_taken_i ? br_target : pcplus4_o;
      NPC_JUMP:   npc_o = jump_target;
      NPC_JAL:    npc_o = jump_target;
      NPC_JR:     npc_o = rs_i;
      NPC_RET:    npc_o = ras_empty ? rs_i : ras_top;
      default:    npc_o = pcplus4_o;
    endcase
  end

  // PC register: redirect beats stall, stall beats the computed next PC.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_reg <= AW'(RESET_PC);
    end else if (redirect_i) begin
      pc_reg <= redirect_pc_i;
    end else if (!stall_i) begin
      pc_reg <= npc_o;
    end
  end

  // Flag a committed RET whose stack prediction disagrees with the register operand.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ret_miss_reg <= 1'b0;
    end else begin
      ret_miss_reg <= commit && (npc_op_i == NPC_RET) && !ras_empty && (ras_top != rs_i);
    end
  end

  // The full flag is informational here; overwrite-on-full is handled inside the stack.
  npc_ras #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rstn  (rstn),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pcplus4_o),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full_unused)
  );

  assign pc_o        = pc_reg;
  assign ras_empty_o = ras_empty;
  assign ret_miss_o  = ret_miss_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of sequential vectors from reset,
// then hand-written sequences for combinational next-PC and async reset.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clk;
  logic        rstn;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [2:0]  npc_op_i;
  logic        br_taken_i;
  logic [25:0] imm_i;
  logic [31:0] rs_i;
  logic [31:0] pc_o;
  logic [31:0] pcplus4_o;
  logic [31:0] npc_o;
  logic        ras_empty_o;
  logic        ret_miss_o;

  int tests_run;
  int tests_failed;

  pc_sequencer #(
    .AW        (32),
    .RESET_PC  (64'h0000_3000),
    .RAS_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .npc_op_i      (npc_op_i),
    .br_taken_i    (br_taken_i),
    .imm_i         (imm_i),
    .rs_i          (rs_i),
    .pc_o          (pc_o),
    .pcplus4_o     (pcplus4_o),
    .npc_o         (npc_o),
    .ras_empty_o   (ras_empty_o),
    .ret_miss_o    (ret_miss_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [2:0]  op;
    logic        bt;
    logic [25:0] imm;
    logic [31:0] rs;
    logic [31:0] exp_pc;
    logic        exp_empty;
    logic        exp_miss;
  } vec_t;

  localparam int NV = 37;
  vec_t vecs [NV];

  function automatic vec_t mk(logic st, logic rd, logic [31:0] rpc, logic [2:0] op,
                              logic bt, logic [25:0] imm, logic [31:0] rs,
                              logic [31:0] epc, logic ee, logic em);
    vec_t v;
    v.stall = st; v.redir = rd; v.rpc = rpc; v.op = op; v.bt = bt;
    v.imm = imm; v.rs = rs; v.exp_pc = epc; v.exp_empty = ee; v.exp_miss = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall_i       = v.stall;
    redirect_i    = v.redir;
    redirect_pc_i = v.rpc;
    npc_op_i      = v.op;
    br_taken_i    = v.bt;
    imm_i         = v.imm;
    rs_i          = v.rs;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Sequence from reset; each row is one clock, expectations are post-edge.
    vecs[0]  = mk(0,0,32'h0,   NPC_PLUS4, 0,26'h0,     32'h0,    32'h3004,1,0);
    vecs[1]  = mk(0,0,32'h0,   NPC_PLUS4, 0,26'h0,     32'h0,    32'h3008,1,0);
    vecs[2]  = mk(0,0,32'h0,   NPC_PLUS4, 0,26'h0,     32'h0,    32'h300C,1,0);
    vecs[3]  = mk(0,1,32'h3010,NPC_PLUS4, 0,26'h0,     32'h0,    32'h3010,1,0);
    vecs[4]  = mk(0,0,32'h0,   NPC_BRANCH,1,26'hFFFE,  32'h0,    32'h300C,1,0);
    vecs[5]  = mk(0,1,32'h3010,NPC_PLUS4, 0,26'h0,     32'h0,    32'h3010,1,0);
    vecs[6]  = mk(0,0,32'h0,   NPC_BRANCH,0,26'hFFFE,  32'h0,    32'h3014,1,0);
    vecs[7]  = mk(0,1,32'h3020,NPC_PLUS4, 0,26'h0,     32'h0,    32'h3020,1,0);
    vecs[8]  = mk(0,0,32'h0,   NPC_JAL,   0,26'h400,   32'h0,    32'h1000,0,0);
    vecs[9]  = mk(0,0,32'h0,   NPC_RET,   0,26'h0,     32'h3024, 32'h3024,1,0);
    vecs[10] = mk(0,0,32'h0,   NPC_BRANCH,1,26'h0004,  32'h0,    32'h3038,1,0);
    vecs[11] = mk(0,0,32'h0,   NPC_JR,    0,26'h0,     32'h2001, 32'h2001,1,0);
    vecs[12] = mk(0,0,32'h0,   3'b111,    1,26'h3FFFFFF,32'h9999,32'h2005,1,0);
    vecs[13] = mk(0,0,32'h0,   NPC_RET,   0,26'h0,     32'h5000, 32'h5000,1,0);
    vecs[14] = mk(0,0,32'h0,   NPC_JAL,   0,26'h100,   32'h0,    32'h0400,0,0);
    vecs[15] = mk(0,0,32'h0,   NPC_JAL,   0,26'h200,   32'h0,    32'h0800,0,0);
    vecs[16] = mk(0,0,32'h0,   NPC_JAL,   0,26'h300,   32'h0,    32'h0C00,0,0);
    vecs[17] = mk(0,0,32'h0,   NPC_JAL,   0,26'h400,   32'h0,    32'h1000,0,0);
    vecs[18] = mk(0,0,32'h0,   NPC_JAL,   0,26'h500,   32'h0,    32'h1400,0,0);
    vecs[19] = mk(0,0,32'h0,   NPC_RET,   0,26'h0,     32'h1004, 32'h1004,0,0);
    vecs[20] = mk(0,0,32'h0,   NPC_RET,   0,26'h0,     32'h0C04, 32'h0C04,0,0);
    vecs[21] = mk(0,0,32'h0,   NPC_RET,   0,26'h0,     32'h0804, 32'h0804,0,0);
    vecs[22] = mk(0,0,32'h0,   NPC_RET,   0,26'h0,     32'h0404, 32'h0404,1,0);
    vecs[23] = mk(0,0,32'h0,   NPC_RET,   0,26'h0,     32'h6000, 32'h6000,1,0);
    vecs[24] = mk(0,0,32'h0,   NPC_JAL,   0,26'h10,    32'h0,    32'h0040,0,0);
    vecs[25] = mk(1,1,32'h4180,NPC_JAL,   0,26'h20,    32'h0,    32'h4180,0,0);
    vecs[26] = mk(1,0,32'h0,   NPC_JAL,   0,26'h20,    32'h0,    32'h4180,0,0);
    vecs[27] = mk(0,0,32'h0,   NPC_RET,   0,26'h0,     32'h6004, 32'h6004,1,0);
    vecs[28] = mk(0,1,32'h3020,NPC_PLUS4, 0,26'h0,     32'h0,    32'h3020,1,0);
    vecs[29] = mk(0,0,32'h0,   NPC_JAL,   0,26'h400,   32'h0,    32'h1000,0,0);
    vecs[30] = mk(0,0,32'h0,   NPC_RET,   0,26'h0,     32'h5000, 32'h3024,1,1);
    vecs[31] = mk(0,0,32'h0,   NPC_PLUS4, 0,26'h0,     32'h0,    32'h3028,1,0);
    vecs[32] = mk(0,1,32'h3020,NPC_PLUS4, 0,26'h0,     32'h0,    32'h3020,1,0);
    vecs[33] = mk(0,0,32'h0,   NPC_JAL,   0,26'h400,   32'h0,    32'h1000,0,0);
    vecs[34] = mk(0,0,32'h0,   NPC_RET,   0,26'h0,     32'h5000, 32'h3024,1,1);
    vecs[35] = mk(1,0,32'h0,   NPC_PLUS4, 0,26'h0,     32'h0,    32'h3024,1,0);
    vecs[36] = mk(0,0,32'h0,   3'b110,    0,26'h0,     32'h0,    32'h3028,1,0);

    // Reset state
    rstn = 1'b0;
    drive(mk(0,0,32'h0,NPC_PLUS4,0,26'h0,32'h0,32'h0,0,0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc",      pc_o,        32'h3000);
    check("reset_pcplus4", pcplus4_o,   32'h3004);
    check("reset_empty",   32'(ras_empty_o), 32'h1);
    check("reset_miss",    32'(ret_miss_o),  32'h0);
    $display("[TB] reset: pc=0x%08h empty=%0d miss=%0d", pc_o, ras_empty_o, ret_miss_o);
    rstn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_pc", i),      pc_o,             vecs[i].exp_pc);
      check($sformatf("vec%0d_empty", i),   32'(ras_empty_o), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d_miss", i),    32'(ret_miss_o),  32'(vecs[i].exp_miss));
      check($sformatf("vec%0d_pcplus4", i), pcplus4_o,        vecs[i].exp_pc + 32'h4);
      $display("[TB] vec %0d: op=%0d stall=%0d redir=%0d pc=0x%08h empty=%0d miss=%0d",
               i, vecs[i].op, vecs[i].stall, vecs[i].redir, pc_o, ras_empty_o, ret_miss_o);
    end

    // Combinational next-PC for a branch from 0x3010, taken and not taken
    drive(mk(0,1,32'h3010,NPC_PLUS4,0,26'h0,32'h0,32'h0,0,0));
    @(posedge clk);
    #1;
    drive(mk(0,0,32'h0,NPC_BRANCH,1,26'hFFFE,32'h0,32'h0,0,0));
    #1;
    check("npc_branch_taken", npc_o, 32'h300C);
    br_taken_i = 1'b0;
    #1;
    check("npc_branch_not_taken", npc_o, 32'h3014);
    npc_op_i = NPC_JAL;
    imm_i    = 26'h400;
    #1;
    check("npc_jal", npc_o, 32'h1000);
    $display("[TB] npc combinational: pc=0x%08h npc=0x%08h", pc_o, npc_o);
    @(posedge clk);
    #1;
    check("pre_reset_pc",    pc_o,             32'h1000);
    check("pre_reset_empty", 32'(ras_empty_o), 32'h0);

    // Async reset asserted mid-cycle while stall and redirect are pending
    drive(mk(1,1,32'h4180,NPC_JAL,0,26'h100,32'h0,32'h0,0,0));
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_pc",    pc_o,             32'h3000);
    check("async_reset_empty", 32'(ras_empty_o), 32'h1);
    check("async_reset_miss",  32'(ret_miss_o),  32'h0);
    @(posedge clk);
    #1;
    check("held_reset_pc", pc_o, 32'h3000);
    $display("[TB] async reset: pc=0x%08h empty=%0d", pc_o, ras_empty_o);
    rstn = 1'b1;
    drive(mk(0,0,32'h0,NPC_RET,0,26'h0,32'h7000,32'h0,0,0));
    @(posedge clk);
    #1;
    check("post_reset_ret_pc",   pc_o,             32'h7000);
    check("post_reset_ret_miss", 32'(ret_miss_o),  32'h0);
    $display("[TB] post-reset RET: pc=0x%08h empty=%0d", pc_o, ras_empty_o);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
